// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
//   SYNC_BYTE_DEFAULT : first byte of every packet unless overridden
//   IDX_W             : width of the byte index (covers packets up to 31 bytes)
//   state_t           : arbiter FSM state encoding
//   pkt_len()         : total packet length for a given payload length
package uart_tx_arbiter_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
    localparam int         IDX_W             = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4
    } state_t;

    // Packet = sync + id + payload + checksum.
    function automatic int pkt_len(input int payload_bytes);
        return payload_bytes + 3;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req        in  N_REQ  request levels
//   last       in  IW     index of the most recent winner
//   win_onehot out N_REQ  one-hot winner (zero when no request)
//   win_idx    out IW     binary index of the winner
//   win_valid  out 1      any request present
// Search starts at last+1 and wraps; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IW-1:0]    win_idx,
    output logic             win_valid
);

    int cand;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        // k runs 1..N_REQ so that the previous winner is examined last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last) + k) % N_REQ;
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    assign win_onehot = win_valid ? (N_REQ'(1) << win_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART byte transmitter with framed packets:
// sync byte, id byte, PAYLOAD_BYTES payload bytes, XOR checksum (id + payload).
//   clk, rst     clock, asynchronous active-high reset
//   req          per-requester request level, held until granted
//   req_data     flattened payloads, requester i at [i*PAYLOAD_BYTES*8 +: PAYLOAD_BYTES*8]
//   grant        one-hot, one-cycle pulse when a payload is latched
//   busy         high from grant until the checksum byte is accepted
//   tx_data      byte presented to the transmitter
//   tx_data_rdy  one-cycle strobe to the transmitter
//   tx_rdy       transmitter idle/ready
//   dbg_state    current FSM state
//
// Handshake: a byte is taken by the transmitter on a clock edge where
// tx_data_rdy & tx_rdy are both high; tx_data is held from LOAD to the next LOAD,
// tx_data_rdy is a single-cycle strobe, and the transmitter signals completion by
// dropping tx_rdy and raising it again.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         N_REQ         = 4,
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req,
    input  logic [N_REQ*PAYLOAD_BYTES*8-1:0]   req_data,
    output logic [N_REQ-1:0]                   grant,
    output logic                               busy,
    output logic [7:0]                         tx_data,
    output logic                               tx_data_rdy,
    input  logic                               tx_rdy,
    output state_t                             dbg_state
);

    localparam int IW       = $clog2(N_REQ);
    localparam int PW       = PAYLOAD_BYTES * 8;
    localparam int LAST_IDX = pkt_len(PAYLOAD_BYTES) - 1;

    state_t             state_q, state_n;
    logic [IW-1:0]      last_q, last_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [PW-1:0]      payload_q, payload_n;
    logic [7:0]         id_q, id_n;
    logic [7:0]         csum_q, csum_n;
    logic [7:0]         tx_data_q, tx_data_n;
    logic               tx_data_rdy_q, tx_data_rdy_n;
    logic [N_REQ-1:0]   grant_q, grant_n;
    logic               busy_q, busy_n;
    logic               hi_seen_q, hi_seen_n;

    logic [N_REQ-1:0]   win_onehot;
    logic [IW-1:0]      win_idx;
    logic               win_valid;
    logic [PW-1:0]      win_payload;
    logic [7:0]         pl_byte;
    logic [7:0]         cur_byte;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req        (req),
        .last       (last_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    // Winner payload and outgoing-byte mux.
    always_comb begin
        win_payload = '0;
        pl_byte     = 8'h00;
        cur_byte    = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_onehot[i]) win_payload = req_data[i*PW +: PW];
        end
        for (int b = 0; b < PAYLOAD_BYTES; b++) begin
            if (idx_q == IDX_W'(b + 2)) pl_byte = payload_q[b*8 +: 8];
        end
        if (idx_q == '0)                      cur_byte = SYNC_BYTE;
        else if (idx_q == IDX_W'(1))          cur_byte = id_q;
        else if (idx_q == IDX_W'(LAST_IDX))   cur_byte = csum_q;
        else                                  cur_byte = pl_byte;
    end

    always_comb begin
        state_n       = state_q;
        last_n        = last_q;
        idx_n         = idx_q;
        payload_n     = payload_q;
        id_n          = id_q;
        csum_n        = csum_q;
        tx_data_n     = tx_data_q;
        tx_data_rdy_n = 1'b0;
        grant_n       = '0;
        busy_n        = busy_q;
        hi_seen_n     = hi_seen_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_n   = win_onehot;
                    busy_n    = 1'b1;
                    last_n    = win_idx;
                    payload_n = win_payload;
                    id_n      = 8'(win_idx);
                    csum_n    = 8'h00;
                    idx_n     = '0;
                    state_n   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_n = cur_byte;
                // Accumulate id and payload bytes; sync and checksum are excluded.
                if (idx_q != '0 && idx_q != IDX_W'(LAST_IDX)) csum_n = csum_q ^ cur_byte;
                state_n = ST_ISSUE;
            end
            ST_ISSUE: begin
                hi_seen_n = 1'b0;
                if (tx_rdy) begin
                    tx_data_rdy_n = 1'b1;
                    state_n       = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                // A transmitter that never drops tx_rdy is treated as having
                // accepted the byte after two consecutive high cycles.
                if (!tx_rdy || hi_seen_q) state_n = ST_WAIT_HI;
                else                      hi_seen_n = 1'b1;
            end
            ST_WAIT_HI: begin
                if (tx_rdy) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        idx_n   = '0;
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        idx_n   = idx_q + IDX_W'(1);
                        state_n = ST_LOAD;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_q        <= IW'(N_REQ - 1);
            idx_q         <= '0;
            payload_q     <= '0;
            id_q          <= 8'h00;
            csum_q        <= 8'h00;
            tx_data_q     <= 8'h00;
            tx_data_rdy_q <= 1'b0;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            hi_seen_q     <= 1'b0;
        end else begin
            state_q       <= state_n;
            last_q        <= last_n;
            idx_q         <= idx_n;
            payload_q     <= payload_n;
            id_q          <= id_n;
            csum_q        <= csum_n;
            tx_data_q     <= tx_data_n;
            tx_data_rdy_q <= tx_data_rdy_n;
            grant_q       <= grant_n;
            busy_q        <= busy_n;
            hi_seen_q     <= hi_seen_n;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign tx_data     = tx_data_q;
    assign tx_data_rdy = tx_data_rdy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N_REQ = 4;
  localparam int PAYLOAD_BYTES = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk;
  logic rst;
  logic [N_REQ-1:0] req;
  logic [N_REQ*PAYLOAD_BYTES*8-1:0] req_data;
  logic [N_REQ-1:0] grant;
  logic busy;
  logic [7:0] tx_data;
  logic tx_data_rdy;
  logic tx_rdy;
  state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N_REQ), .PAYLOAD_BYTES(PAYLOAD_BYTES), .SYNC_BYTE(8'hAA)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant), .busy(busy),
    .tx_data(tx_data), .tx_data_rdy(tx_data_rdy), .tx_rdy(tx_rdy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  bit cap_busy_q[$];
  logic [N_REQ-1:0] grant_q[$];
  int strobe_cnt = 0;
  int busy_rise = 0;
  int grant_while_busy = 0;
  int bad_onehot = 0;
  bit busy_d = 1'b0;

  // ---------------- transmitter model + monitors (negedge) ----------------
  bit force_low = 1'b0;
  bit never_drop = 1'b0;
  bit pend_drop = 1'b0;
  int lo_cnt = 0;

  always @(negedge clk) begin
    if (tx_data_rdy) strobe_cnt++;
    if (|grant) begin
      grant_q.push_back(grant);
      if (busy_d) grant_while_busy++;
      if (!$onehot(grant)) bad_onehot++;
    end
    if (busy && !busy_d) busy_rise++;
    busy_d = busy;
    // acceptance uses the tx_rdy value that holds across the coming posedge
    if (!force_low && tx_data_rdy && tx_rdy) begin
      cap_q.push_back(tx_data);
      cap_busy_q.push_back(busy);
      if (!never_drop) pend_drop = 1'b1;
    end else if (force_low) begin
      tx_rdy = 1'b0;
      pend_drop = 1'b0;
      lo_cnt = 0;
    end else if (pend_drop) begin
      pend_drop = 1'b0;
      tx_rdy = 1'b0;
      lo_cnt = 10;
    end else if (!tx_rdy) begin
      if (lo_cnt > 1) lo_cnt--;
      else begin
        lo_cnt = 0;
        tx_rdy = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_payload(input int i, input logic [31:0] d);
    req_data[i*32 +: 32] = d;
  endtask

  task automatic push_pkt(input int id, input logic [31:0] d);
    logic [7:0] cs;
    cs = 8'(id);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'(id));
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(d[b*8 +: 8]);
      cs = cs ^ d[b*8 +: 8];
    end
    exp_q.push_back(cs);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    cap_q.delete();
    cap_busy_q.delete();
    grant_q.delete();
    strobe_cnt = 0;
    busy_rise = 0;
    grant_while_busy = 0;
    bad_onehot = 0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (cap_q.size() >= n && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (tx_data_rdy !== 1'b0) begin failures++; $display("FAIL reset_tx_data_rdy: got %b expected 0", tx_data_rdy); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int lat;
    logic [7:0] tbl [7];
    int nb;
    tbl = '{8'hAA, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
    clear_sb();
    set_payload(2, 32'h44332211);
    req = 4'b0100;
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b expected 0100", grant); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_at_grant: got %b expected 1", busy); end
    req = 4'b0000;
    lat = 0;
    while (!tx_data_rdy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 2) begin failures++; $display("FAIL single_first_strobe_latency: got %0d expected 2", lat); end
    wait_done(7, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: got %0d bytes expected 7", cap_q.size()); end
    checks++; if (cap_q.size() != 7) begin failures++; $display("FAIL single_len: got %0d expected 7", cap_q.size()); end
    nb = (cap_q.size() < 7) ? cap_q.size() : 7;
    for (int k = 0; k < nb; k++) begin
      checks++; if (cap_q[k] !== tbl[k]) begin failures++; $display("FAIL single_byte%0d: got %h expected %h", k, cap_q[k], tbl[k]); end
    end
    checks++; if (strobe_cnt != 7) begin failures++; $display("FAIL single_strobes: got %0d expected 7", strobe_cnt); end
    for (int k = 0; k < cap_busy_q.size(); k++) begin
      checks++; if (cap_busy_q[k] !== 1'b1) begin failures++; $display("FAIL single_busy_span%0d: got 0 expected 1", k); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int k;
    logic [31:0] pl [4];
    logic [3:0] exp_g [5];
    int order [5];
    pl = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h5A5AA5A5};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    order = '{0, 1, 2, 3, 0};
    do_reset();
    clear_sb();
    for (int i = 0; i < 4; i++) set_payload(i, pl[i]);
    for (int i = 0; i < 5; i++) push_pkt(order[i], pl[order[i]]);
    req = 4'b1111;
    k = 0;
    while (grant_q.size() < 5 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    req = 4'b0000;
    checks++; if (grant_q.size() != 5) begin failures++; $display("FAIL rr_grant_count: got %0d expected 5", grant_q.size()); end
    for (int i = 0; i < 5 && i < grant_q.size(); i++) begin
      checks++; if (grant_q[i] !== exp_g[i]) begin failures++; $display("FAIL rr_grant%0d: got %b expected %b", i, grant_q[i], exp_g[i]); end
    end
    wait_done(35, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_timeout: got %0d bytes expected 35", cap_q.size()); end
    checks++; if (cap_q.size() != 35) begin failures++; $display("FAIL rr_len: got %0d expected 35", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]); end
    end
    checks++; if (busy_rise != 5) begin failures++; $display("FAIL rr_busy_packets: got %0d expected 5", busy_rise); end
    checks++; if (grant_while_busy != 0) begin failures++; $display("FAIL rr_grant_while_busy: got %0d expected 0", grant_while_busy); end
    checks++; if (bad_onehot != 0) begin failures++; $display("FAIL rr_onehot: got %0d expected 0", bad_onehot); end
  endtask

  task automatic test_latch();
    bit ok;
    clear_sb();
    set_payload(3, 32'hCAFEF00D);
    push_pkt(3, 32'hCAFEF00D);
    req = 4'b1000;
    @(negedge clk);
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL latch_grant: got %b expected 1000", grant); end
    set_payload(3, 32'h12345678);
    req = 4'b0000;
    wait_done(7, ok);
    checks++; if (!ok || cap_q.size() != 7) begin failures++; $display("FAIL latch_len: got %0d expected 7", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL latch_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_sb();
    force_low = 1'b1;
    @(negedge clk);
    set_payload(1, 32'h0F1E2D3C);
    push_pkt(1, 32'h0F1E2D3C);
    req = 4'b0010;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL stall_grant: got %b expected 0010", grant); end
    req = 4'b0000;
    repeat (48) @(negedge clk);
    checks++; if (strobe_cnt != 0) begin failures++; $display("FAIL stall_no_strobe: got %0d expected 0", strobe_cnt); end
    checks++; if (dbg_state !== ST_ISSUE) begin failures++; $display("FAIL stall_state: got %0d expected %0d", dbg_state, ST_ISSUE); end
    force_low = 1'b0;
    wait_done(7, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout: got %0d bytes expected 7", cap_q.size()); end
    checks++; if (strobe_cnt != 7) begin failures++; $display("FAIL stall_strobes: got %0d expected 7", strobe_cnt); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    int sc;
    clear_sb();
    set_payload(0, 32'h55667788);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    k = 0;
    while (cap_q.size() < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++; if (cap_q.size() < 4) begin failures++; $display("FAIL rstmid_reach_byte: got %0d bytes expected 4", cap_q.size()); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx_data: got %h expected 00", tx_data); end
    checks++; if (tx_data_rdy !== 1'b0 || grant !== 4'b0000) begin failures++; $display("FAIL rstmid_strobe_grant: got %b/%b expected 0/0000", tx_data_rdy, grant); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    sc = strobe_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (!tx_rdy && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++; if (strobe_cnt != sc) begin failures++; $display("FAIL rstmid_no_strobe: got %0d expected %0d", strobe_cnt, sc); end
    clear_sb();
    set_payload(0, 32'hA1B2C3D4);
    set_payload(3, 32'h99999999);
    push_pkt(0, 32'hA1B2C3D4);
    req = 4'b1001;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rstmid_priority: got %b expected 0001", grant); end
    req = 4'b0000;
    wait_done(7, ok);
    checks++; if (!ok || cap_q.size() != 7) begin failures++; $display("FAIL rstmid_len: got %0d expected 7", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_no_drop();
    bit ok;
    clear_sb();
    never_drop = 1'b1;
    set_payload(2, 32'h44332211);
    push_pkt(2, 32'h44332211);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    wait_done(7, ok);
    checks++; if (!ok) begin failures++; $display("FAIL nodrop_timeout: got %0d bytes expected 7", cap_q.size()); end
    checks++; if (strobe_cnt != 7) begin failures++; $display("FAIL nodrop_strobes: got %0d expected 7", strobe_cnt); end
    checks++; if (cap_q.size() != 7) begin failures++; $display("FAIL nodrop_len: got %0d expected 7", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL nodrop_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]); end
    end
    never_drop = 1'b0;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    tx_rdy = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_latch();
    test_stall();
    test_reset_mid();
    test_no_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
